mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one repeated-addition multiplier datapath (A reg, B down-counter with eqz flag, P accumulator) among NREQ requesters.
- Grants one requester at a time, steers its operands onto the datapath input bus, and drives LdA/LdB/LdP/clrP/decB.
- Watches eqz and returns a one-cycle ack to the winner when the datapath's P register holds A*B.
- Sits between the requester clients and the multiplier datapath; replaces the single-user start/done controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand and data bus width.
- TIMEOUT_CYC, 1023, maximum RUN cycles before abort; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- opa  input  NREQ*W  operand A per requester; slice i is bits [i*W +: W].
- opb  input  NREQ*W  operand B (multiplier count) per requester, same packing.
- gnt  output  NREQ  one-hot grant, held for the whole operation.
- ack  output  NREQ  one-cycle pulse to the winner; P is valid this cycle.
- busy  output  1  high in any state other than IDLE.
- dp_data  output  W  operand bus into the datapath.
- LdA  output  1  datapath A load.
- LdB  output  1  datapath B load.
- LdP  output  1  datapath P load (P <= P + A).
- clrP  output  1  datapath P clear.
- decB  output  1  datapath B decrement.
- eqz  input  1  datapath flag, B == 0.
- err  output  1  timeout abort pulse; constant 0 when the optional feature is compiled out.

Behaviour:
- Timing and defaults:
  - Single clock domain.
  - State register, grant index and round-robin pointer are all registered.
  - Datapath control outputs are decoded from state, with RUN outputs qualified by eqz.
- Reset: rst high at a clock edge forces the following, regardless of state (including mid-RUN):
  - state = IDLE;
  - gnt, ack, busy, err, LdA, LdB, LdP, clrP and decB all 0;
  - dp_data = 0;
  - rr pointer = NREQ-1, so requester 0 wins first.
- States and transitions:
  - IDLE: all controls 0.
    - If req != 0, select the winner: the first set bit searching upward from rr+1 with wrap-around.
    - Register the winner index, set gnt, go to LDA.
  - LDA: dp_data = opa[win], LdA = 1. Next state LDB.
  - LDB: dp_data = opb[win], LdB = 1, clrP = 1. Next state RUN.
  - RUN, eqz = 0: LdP = 1, decB = 1, stay in RUN.
  - RUN, eqz = 1: LdP = 0, decB = 0, go to DONE.
    - opb = 0 therefore yields P = 0 with no LdP pulse.
  - DONE: ack[win] = 1 for exactly one cycle; rr = win; gnt cleared; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0: LdA at cycle 1, LdB at cycle 2, RUN from cycle 3.
  - ack at cycle opb + 4.
  - The next grant is issued no earlier than 1 cycle after ack (the IDLE cycle).
- Operands: opa and opb are sampled only in LDA and LDB respectively. Later changes do not affect the operation in flight.
- Requester drops req mid-operation: the operation completes and ack still pulses. There is no cancel.
- Requester holds req through ack: it is treated as a new request. Round-robin guarantees every other pending requester is served first.
- Simultaneous requests: exactly one grant. gnt is always one-hot or zero.
- Arithmetic: the datapath owns the multiplication width. The controller does no arithmetic beyond the pointer wrap modulo NREQ.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC while eqz is still 0, the controller forces LdP = 0 and decB = 0 and goes to DONE.
  - ack[win] pulses and err pulses in the same cycle.
  - rr updates as normal.
- When undefined:
  - There is no counter.
  - err is tied to 0.
  - RUN exits only on eqz.

Test Plan:
- Reset then single request: req = 0001, opa = 7, opb = 3 -> LdA at cycle 1, LdB+clrP at cycle 2, LdP/decB for 3 cycles, ack = 0001 at cycle 7, datapath P = 21.
- opb = 0: req = 0010, opa = 9 -> no LdP pulse, ack = 0010 at cycle 4, P = 0.
- Fairness: req = 1111 held, opb = 1 each -> grants in order 0, 1, 2, 3, 0; each ack is 5 cycles after its grant.
- Contention after service: requester 2 finishes with req = 0101 pending -> next grant = 0 (wrap), then 2.
- Reset mid-RUN: rst asserted in the 2nd RUN cycle -> next cycle all outputs 0 and IDLE; with req = 1000, grant goes to 3; after reset with req = 1111, grant goes to 0.
- MUL_TIMEOUT_EN with TIMEOUT_CYC = 4 and a datapath model holding eqz = 0 -> exactly 4 LdP pulses, then ack and err high together for one cycle.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// ============================================================================
// Module      : mul_share_ctrl
// Description : Round-robin sequencer sharing one repeated-addition multiplier
//               datapath among NREQ requesters. Optional RUN timeout abort
//               is compiled in with the MUL_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_share_ctrl #(
    parameter int NREQ        = 4,
    parameter int W           = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [W-1:0]      dp_data,
    output logic              LdA,
    output logic              LdB,
    output logic              LdP,
    output logic              clrP,
    output logic              decB,
    input  logic              eqz,
    output logic              err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_win;
    logic [IW-1:0] r_rr;
    logic [IW-1:0] w_pick;
    logic          w_found;
    logic [IW:0]   w_cand;
    logic          w_expire;

    // Search upward from the slot after the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_rr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(NREQ)) begin
                w_cand = w_cand - (IW+1)'(NREQ);
            end
            if (!w_found && req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IW-1:0];
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_expire = (r_state == S_RUN) && !eqz && (r_cnt == CW'(TIMEOUT_CYC));

    // Counter is zeroed in LDB so it reads 0 on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_LDB) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN && r_cnt != CW'(TIMEOUT_CYC)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
                r_timeout <= w_expire;
            end
        end
    end

    assign err = (r_state == S_DONE) && r_timeout;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_rr    <= IW'(NREQ - 1);
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_win <= w_pick;
            end
            if (r_state == S_DONE) begin
                r_rr <= r_win;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        gnt     = '0;
        ack     = '0;
        dp_data = '0;
        LdA     = 1'b0;
        LdB     = 1'b0;
        LdP     = 1'b0;
        clrP    = 1'b0;
        decB    = 1'b0;
        busy    = (r_state != S_IDLE);
        if (r_state != S_IDLE) begin
            gnt = NREQ'(1) << r_win;
        end
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_LDA;
                end
            end
            S_LDA: begin
                dp_data = opa[r_win*W +: W];
                LdA     = 1'b1;
                w_next  = S_LDB;
            end
            S_LDB: begin
                dp_data = opb[r_win*W +: W];
                LdB     = 1'b1;
                clrP    = 1'b1;
                w_next  = S_RUN;
            end
            S_RUN: begin
                if (eqz || w_expire) begin
                    w_next = S_DONE;
                end else begin
                    LdP  = 1'b1;
                    decB = 1'b1;
                end
            end
            S_DONE: begin
                ack    = NREQ'(1) << r_win;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
// ============================================================================
// Module      : tb_mul_share_ctrl
// Description : Self-checking bench for mul_share_ctrl with a timeline-based
//               reference model and a simple multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 16;
`ifdef MUL_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1023;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int VW = 2*NREQ + W + 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] opa;
    logic [NREQ*W-1:0] opb;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [W-1:0]      dp_data;
    logic              LdA, LdB, LdP, clrP, decB, err;
    logic              eqz;

    int vectors     = 0;
    int miscompares = 0;

    mul_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .ack(ack), .busy(busy), .dp_data(dp_data),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .eqz(eqz), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath environment: A reg, B down-counter, P accumulator.
    logic [W-1:0]   dA = '0;
    logic [W-1:0]   dB = '0;
    logic [2*W-1:0] dP = '0;
    assign eqz = (dB == '0);

    always @(posedge clk) begin
        if (LdA) dA <= dp_data;
        if (LdB) dB <= dp_data;
        else if (decB) dB <= dB - 1'b1;
        if (clrP) dP <= '0;
        else if (LdP) dP <= dP + {{W{1'b0}}, dA};
    end

    // Reference model: one operation is a timeline indexed by d, the cycle
    // offset after the arbitration edge; RUN length is min(B, timeout).
    bit m_busy = 1'b0;
    bit started = 1'b0;
    int m_d = 0, m_win = 0, m_rr = NREQ-1, m_a = 0, m_b = 0, m_len = 0;
    int glog[$];

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_busy = 1'b0;
            m_rr   = NREQ-1;
            m_d    = 0;
        end else if (m_busy) begin
            if (m_d == 1) m_a = int'(opa[m_win*W +: W]);
            if (m_d == 2) begin
                m_b   = int'(opb[m_win*W +: W]);
                m_len = (TO_EN && m_b > TO) ? TO : m_b;
            end
            if (m_d >= 3 && m_d == m_len + 4) begin
                m_busy = 1'b0;
                m_rr   = m_win;
                m_d    = 0;
            end else begin
                m_d++;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!m_busy && req[(m_rr + k) % NREQ]) begin
                    m_win  = (m_rr + k) % NREQ;
                    m_busy = 1'b1;
                end
            end
            m_d = 1;
            glog.push_back(m_win);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] outs();
        return {gnt, ack, busy, dp_data, LdA, LdB, LdP, clrP, decB, err};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            logic [NREQ-1:0] e_gnt, e_ack;
            logic [W-1:0]    e_dp;
            logic            e_run, e_done, e_err;
            e_run  = m_busy && m_d >= 3 && m_d <= m_len + 2;
            e_done = m_busy && m_d >= 3 && m_d == m_len + 4;
            e_gnt  = m_busy ? (NREQ'(1) << m_win) : '0;
            e_ack  = e_done ? (NREQ'(1) << m_win) : '0;
            e_err  = e_done && TO_EN && (m_b > TO);
            e_dp   = '0;
            if (m_busy && m_d == 1) e_dp = opa[m_win*W +: W];
            if (m_busy && m_d == 2) e_dp = opb[m_win*W +: W];
            chk("cycle_outputs", 64'(outs()),
                64'({e_gnt, e_ack, m_busy, e_dp, m_busy && m_d == 1, m_busy && m_d == 2,
                     e_run, m_busy && m_d == 2, e_run, e_err}));
            if (e_done && !e_err) chk("product_at_ack", 64'(dP), 64'(m_a * m_b));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(int r, int a, int b);
        opa[r*W +: W] = W'(a);
        opb[r*W +: W] = W'(b);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        glog.delete();
    endtask

    task automatic run_one(int r, int a, int b, int e_lat, int e_p, int e_ldp, bit e_err);
        int n = 0, ldp = 0;
        bit got = 1'b0;
        set_ops(r, a, b);
        req = NREQ'(1) << r;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (LdP) ldp++;
            if (ack != '0) begin
                got = 1'b1;
                chk("ack_value", 64'(ack), 64'(NREQ'(1) << r));
                chk("ack_latency", 64'(n), 64'(e_lat));
                chk("p_at_ack", 64'(dP), 64'(e_p));
                chk("ldp_pulses", 64'(ldp), 64'(e_ldp));
                chk("err_at_ack", 64'(err), 64'(e_err));
            end
        end
        if (!got) chk("ack_wait_expired", 64'(0), 64'(1));
        #1;
        req = '0;
    endtask

    task automatic wait_grants(int n);
        int t = 0;
        while (glog.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (glog.size() < n) chk("grant_wait_expired", 64'(glog.size()), 64'(n));
        #1;
    endtask

    task automatic drain();
        int t = 0;
        req = '0;
        step();
        while (busy && t < 300) begin
            step();
            t++;
        end
        if (busy) chk("drain_expired", 64'(busy), 64'(0));
    endtask

    initial begin
        int exp_fair[5] = '{0, 1, 2, 3, 0};
        int exp_cont[3] = '{2, 0, 2};
        rst = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        repeat (3) step();
        chk("reset_outputs", 64'(outs()), 64'(0));
        rst = 1'b0;
        glog.delete();
        step();

`ifdef MUL_TIMEOUT_EN
        run_one(0, 3, 9, 8, 12, 4, 1'b1);
        step();
`endif
        run_one(0, 7, 3, 7, 21, 3, 1'b0);
        step();
        run_one(1, 9, 0, 4, 0, 0, 1'b0);
        step();

        // Fairness with all requesters held.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, i + 2, 1);
        req = '1;
        wait_grants(5);
        drain();
        for (int i = 0; i < 5; i++) chk("fair_order", 64'(glog[i]), 64'(exp_fair[i]));

        // Contention after requester 2 is served.
        pulse_reset();
        req = 4'b0100;
        wait_grants(1);
        req = 4'b0101;
        wait_grants(3);
        drain();
        for (int i = 0; i < 3; i++) chk("contention_order", 64'(glog[i]), 64'(exp_cont[i]));

        // Reset during the second RUN cycle.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 5, 5);
        req = '1;
        begin
            int t = 0;
            while (!LdP && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!LdP) chk("run_wait_expired", 64'(0), 64'(1));
        end
        step();
        rst = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        chk("mid_run_reset_outputs", 64'(outs()), 64'(0));
        #1;
        rst = 1'b0;
        wait_grants(2);
        chk("grant_after_reset_req3", 64'(glog[1]), 64'(3));
        drain();
        pulse_reset();
        req = '1;
        wait_grants(1);
        chk("grant_after_reset_all", 64'(glog[0]), 64'(0));
        drain();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) set_ops(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 6)));
            end
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
